// File: rtl/isa_pkg.sv
// ----------------------------------------------------------------------------
// isa_pkg
// Shared definitions for the 20-bit ISA core front end.
//   - IW / PW / RW : instruction word, instruction pointer and register field
//                    widths.
//   - Field bit positions inside the instruction word.
//   - opcode_e     : opcode encodings of the defined instructions.
//   - state_e      : fetch/decode sequencer states.
//   - is_defined_op: tells defined opcodes apart from the undefined space.
// ----------------------------------------------------------------------------
package isa_pkg;

    localparam int IW   = 20;
    localparam int PW   = 9;
    localparam int RW   = 5;
    localparam int OFFW = 15;

    // Instruction word layout: opcode | rd | b_is_const | b_sel | ra.
    // Branches reuse the low 15 bits as a signed pc-relative offset.
    localparam int OP_MSB  = 19;
    localparam int OP_LSB  = 15;
    localparam int RD_MSB  = 14;
    localparam int RD_LSB  = 10;
    localparam int BC_BIT  = 9;
    localparam int BS_MSB  = 8;
    localparam int BS_LSB  = 5;
    localparam int RA_MSB  = 4;
    localparam int RA_LSB  = 0;
    localparam int OFF_MSB = 14;
    localparam int OFF_LSB = 0;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000,
        OP_SUB  = 5'b00001,
        OP_XOR  = 5'b00010,
        OP_AND  = 5'b00011,
        OP_SLL  = 5'b00100,
        OP_SRL  = 5'b00101,
        OP_CMP  = 5'b00110,
        OP_BE   = 5'b00111,
        OP_BL   = 5'b01000,
        OP_BG   = 5'b01001,
        OP_BA   = 5'b01010,
        OP_MOV  = 5'b01011,
        OP_LD   = 5'b01100,
        OP_ST   = 5'b01101,
        OP_DONE = 5'b01110
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    // Every opcode above DONE (01111 and the whole 1xxxx half) is undefined.
    function automatic logic is_defined_op(input logic [4:0] op);
        return (op <= OP_DONE);
    endfunction

endpackage

// File: rtl/instr_fetch_decode_branch_unit.sv
// ----------------------------------------------------------------------------
// branch_unit
// Combinational branch resolution, kept separate so a future branch predictor
// can reuse it.
//   opcode   : opcode of the instruction in the decode stage
//   flag_eq  : compare result, equal
//   flag_lt  : compare result, less-than
//   flag_gt  : compare result, greater-than
//   pc       : address the decoded instruction was fetched from
//   offset   : signed 15-bit pc-relative branch offset
//   taken    : the opcode is a branch and its condition holds
//   target   : pc + sign-extended offset, wrapped to the pointer width
// ----------------------------------------------------------------------------
module branch_unit
    import isa_pkg::*;
(
    input  logic [4:0]      opcode,
    input  logic            flag_eq,
    input  logic            flag_lt,
    input  logic            flag_gt,
    input  logic [PW-1:0]   pc,
    input  logic [OFFW-1:0] offset,
    output logic            taken,
    output logic [PW-1:0]   target
);

    // Wide enough to hold either the pointer or the offset, so the add is
    // correct whichever of the two is wider; the result then wraps to PW bits.
    localparam int XW = (PW > OFFW) ? PW : OFFW;

    logic [XW-1:0] offset_ext;

    // Only the four branch opcodes can be taken; everything else falls through.
    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BE:   taken = flag_eq;
            OP_BL:   taken = flag_lt;
            OP_BG:   taken = flag_gt;
            OP_BA:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    assign offset_ext = XW'($signed(offset));
    assign target     = PW'(XW'(pc) + offset_ext);

endmodule

// File: rtl/instr_fetch_decode.sv
// ----------------------------------------------------------------------------
// instr_fetch_decode
// Front end of the 20-bit ISA core: a two-stage fetch (F) / decode (D)
// pipeline with branch resolution and a start/halt sequencer.
//   Clk, Reset     : core clock, synchronous active-high reset
//   Start          : one-cycle pulse, (re)start execution at start_addr
//   start_addr     : program entry point
//   iptr           : address to the combinational instruction LUT
//   inst           : instruction word returned by the LUT this cycle
//   flag_eq/lt/gt  : registered compare flags from the execute stage
//   dec_valid      : decoded fields must be executed this cycle
//   opcode, rd, b_is_const, b_sel, ra : raw fields of the decoded word
//   wr_en, mem_rd, mem_wr, flag_wr    : execute-stage control strobes
//   Ack            : program halted (level)
//   illegal        : undefined opcode trapped (only with the trap build)
// Build option: define ILLEGAL_OP_TRAP_EN to halt on undefined opcodes and
// expose the illegal output; otherwise undefined opcodes execute as NOPs.
// ----------------------------------------------------------------------------
module instr_fetch_decode
    import isa_pkg::*;
(
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [PW-1:0] start_addr,
    output logic [PW-1:0] iptr,
    input  logic [IW-1:0] inst,
    input  logic          flag_eq,
    input  logic          flag_lt,
    input  logic          flag_gt,
    output logic          dec_valid,
    output logic [4:0]    opcode,
    output logic [RW-1:0] rd,
    output logic          b_is_const,
    output logic [3:0]    b_sel,
    output logic [RW-1:0] ra,
    output logic          wr_en,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          flag_wr,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic          illegal,
`endif
    output logic          Ack
);

    state_e        state;
    state_e        state_next;

    logic [PW-1:0] pc;
    logic          d_valid;
    logic [IW-1:0] d_inst;
    logic [PW-1:0] d_pc;

    logic [4:0]    d_op;
    logic          run_valid;
    logic          is_done;
    logic          trap_hit;
    logic          halt_req;
    logic          bu_taken;
    logic [PW-1:0] bu_target;
    logic          br_taken;

    assign d_op      = d_inst[OP_MSB:OP_LSB];
    assign run_valid = d_valid & (state == RUN);
    assign is_done   = (d_op == OP_DONE);

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_q;

    assign trap_hit = run_valid & ~is_defined_op(d_op);

    // Sticky trap indication; only a restart or reset clears it, and a
    // restart in the same cycle as the trap wins.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            illegal_q <= 1'b0;
        end else if (Start) begin
            illegal_q <= 1'b0;
        end else if (trap_hit) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`else
    assign trap_hit = 1'b0;
`endif

    assign halt_req = run_valid & (is_done | trap_hit);

    branch_unit u_branch_unit (
        .opcode  (d_op),
        .flag_eq (flag_eq),
        .flag_lt (flag_lt),
        .flag_gt (flag_gt),
        .pc      (d_pc),
        .offset  (d_inst[OFF_MSB:OFF_LSB]),
        .taken   (bu_taken),
        .target  (bu_target)
    );

    assign br_taken = dec_valid & bu_taken;

    // Sequencer state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Start always leads to RUN, even when already running (restart);
    // a done or trapped opcode in decode parks the sequencer in HALT.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = RUN;
            RUN:     if (!Start && halt_req) state_next = HALT;
            HALT:    if (Start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Sequencer outputs. The done word itself is never executed, and the
    // control strobes are gated so flushed or halted slots cannot write.
    always_comb begin
        iptr      = (state == IDLE) ? '0 : pc;
        Ack       = (state == HALT);
        dec_valid = run_valid & ~is_done & ~trap_hit;
        wr_en     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        flag_wr   = 1'b0;
        if (dec_valid) begin
            case (d_op)
                OP_ADD, OP_SUB, OP_XOR, OP_AND,
                OP_SLL, OP_SRL, OP_MOV: wr_en = 1'b1;
                OP_LD: begin
                    wr_en  = 1'b1;
                    mem_rd = 1'b1;
                end
                OP_ST:   mem_wr  = 1'b1;
                OP_CMP:  flag_wr = 1'b1;
                default: ;
            endcase
        end
    end

    // Fetch pointer and decode register. Priority inside RUN is restart,
    // then halt (pc frozen), then taken branch (which drops the word fetched
    // alongside it, one bubble), then the normal sequential fetch.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc      <= '0;
            d_valid <= 1'b0;
            d_inst  <= '0;
            d_pc    <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (Start) begin
                        pc      <= start_addr;
                        d_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (Start) begin
                        pc      <= start_addr;
                        d_valid <= 1'b0;
                    end else if (halt_req) begin
                        d_valid <= 1'b0;
                    end else if (br_taken) begin
                        pc      <= bu_target;
                        d_valid <= 1'b0;
                    end else begin
                        d_inst  <= inst;
                        d_pc    <= pc;
                        d_valid <= 1'b1;
                        pc      <= pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign opcode     = d_op;
    assign rd         = d_inst[RD_MSB:RD_LSB];
    assign b_is_const = d_inst[BC_BIT];
    assign b_sel      = d_inst[BS_MSB:BS_LSB];
    assign ra         = d_inst[RA_MSB:RA_LSB];

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Front end of the 20-bit ISA core. Drives the instruction pointer into the combinational instruction LUT, registers the returned word, and decodes it into control fields for the register file and ALU.
- Resolves branches against the compare flags and halts on `done`.
- Sits between the instruction LUT and the reg-file/ALU/data-mem execute stage.

Parameters:
- IW, 20, instruction word width.
- PW, 9, instruction pointer width (512-entry program space).
- RW, 5, width of each register/operand field.

Ports:
- Clk  in  1  core clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle pulse: begin executing at start_addr.
- start_addr  in  PW  program entry point.
- iptr  out  PW  address to instruction LUT.
- inst  in  IW  instruction word returned by the LUT in the same cycle.
- flag_eq  in  1  compare result, equal.
- flag_lt  in  1  compare result, less-than.
- flag_gt  in  1  compare result, greater-than.
- dec_valid  out  1  decoded fields are valid and must be executed this cycle.
- opcode  out  5  inst[19:15] of the decoded instruction.
- rd  out  RW  inst[14:10].
- b_is_const  out  1  inst[9]; when 1, operand B is a constant-LUT index.
- b_sel  out  4  inst[8:5]; register number or constant index.
- ra  out  RW  inst[4:0].
- wr_en  out  1  register write enable (add, sub, xor, and, sll, srl, mov, ld).
- mem_rd  out  1  ld.
- mem_wr  out  1  st.
- flag_wr  out  1  cmp.
- Ack  out  1  program halted (level).

Behaviour:
- Pipeline, stage F: iptr = pc, combinational from the pc register. At the clock edge, {inst, pc} are captured into the D register and pc <= pc+1, modulo 2^PW (511 wraps to 0).
- Pipeline, stage D: outputs are decoded combinationally from the D register. dec_valid = D.valid & state==RUN.
- Flags are produced downstream by the cmp executing in D and are registered at that edge. A branch in the following D cycle therefore sees the updated flags; no forwarding is done here.
- Branch opcodes and conditions: be 00111 taken if flag_eq; bl 01000 taken if flag_lt; bg 01001 taken if flag_gt; ba 01010 always taken.
- Branch target = D.pc + sign-extend(inst[14:0]), truncated to PW bits (wrap-around is legal).
- Taken branch: pc <= target, and D.valid <= 0 for the next cycle. This flushes the word fetched in the same cycle, costing one bubble.
- Not-taken branch: no bubble.
- FSM IDLE (reset state): iptr=0, dec_valid=0, Ack=0. Start moves to RUN with pc<=start_addr, D.valid<=0.
- FSM RUN: fetch and decode every cycle. When D holds `done` (01110): dec_valid=0 for that cycle, go to HALT, D.valid<=0, pc frozen.
- FSM HALT: Ack=1. iptr holds the pc value at halt. Start re-enters RUN exactly as from IDLE and Ack drops in the next cycle.
- Start asserted while in RUN: restart. pc<=start_addr, D flushed; Start takes priority over a taken branch in the same cycle.
- Reset has priority over all inputs, and mid-program takes effect on the next edge:
  - state=IDLE, pc=0, D.valid=0, D=0.
  - Outputs: dec_valid=0, Ack=0, all decoded fields 0, wr_en/mem_rd/mem_wr/flag_wr=0.
- Branch instructions, `done`, and undefined opcodes assert none of wr_en/mem_rd/mem_wr/flag_wr.
- Without the optional feature, undefined opcodes (01111, 1xxxx) are treated as NOPs.
- Latency: the first instruction reaches D one cycle after Start. Steady state is 1 instruction per cycle.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- When defined: an extra output `illegal` (1 bit). An undefined opcode in D with D.valid forces HALT with Ack=1 and illegal=1. illegal is cleared by Start or Reset.
- When undefined: the port is absent and undefined opcodes execute as NOPs.

Decomposition:
- Package isa_pkg:
  - opcode enum (ADD, SUB, XOR, AND, SLL, SRL, CMP, BE, BL, BG, BA, MOV, LD, ST, DONE).
  - Field bit-position constants.
  - IW/PW localparams.
  - FSM state enum {IDLE, RUN, HALT}.
- Sub-module branch_unit: inputs opcode, flags, D.pc, offset; outputs taken and target. Purely combinational, reused by any future branch predictor.

Test Plan:
- Reset high 3 cycles mid-RUN -> next cycle state IDLE, iptr=0, dec_valid=0, Ack=0, all control outputs 0.
- Start with start_addr=0x001; LUT holds add r4,r1,r4 (00000_00100_00001_00100) at 0x001 -> iptr=0x001 then 0x002. Cycle after Start: dec_valid=1, opcode=0, rd=4, b_is_const=0, b_sel=1, ra=4, wr_en=1.
- bl at 0x010 with offset 0x7FF3 (-13), flag_lt=1 -> iptr=0x003 next cycle, one cycle dec_valid=0. Repeat with flag_lt=0 -> iptr continues at 0x012 with no bubble.
- cmp r7,8 (00110_00000_10100_00111): flag_wr=1, b_is_const=1, b_sel=4, wr_en=0. Next-cycle be with flag_eq=1 -> taken to pc+offset.
- done at 0x000 reached via ba -> dec_valid=0, Ack=1 held for 10 cycles, iptr stable. Start with start_addr=0x019 -> Ack=0 and fetch resumes at 0x019.
- With ILLEGAL_OP_TRAP_EN, opcode 10000 in D -> HALT with Ack=1, illegal=1. Start clears both.
